instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Multi-cycle fetch/decode/control sequencer for the 16-bit CPU. It owns the PC and the instruction register (IR) and sequences memory accesses. It presents the raw 4-bit register fields and 8-bit immediate field to the register/immediate translation stage directly downstream. It also generates the write, memory and PC-update strobes that qualify that stage's one-hot write-enable and sign-extended immediate.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
mem_rdata  in  16  memory read data, valid one cycle after mem_addr is presented (synchronous read)
src_data  in  16  register-file read data for the rsrc field (memory/jump address)
cond_true  in  1  external condition evaluation of cond_field, sampled in EXEC
mem_addr  out  16  memory address
mem_we  out  1  memory write strobe (store data path is external)
rsrc_field  out  4  IR[3:0], to translation stage rsrc input
rdst_field  out  4  IR[11:8], to translation stage rdst input
imm_field  out  8  IR[7:0], to translation stage immediate input
cond_field  out  4  IR[11:8], to condition evaluator
alu_op  out  8  {IR[15:12], IR[7:4]}
imm_sel  out  1  1 = ALU B operand is the sign-extended immediate
reg_wen  out  1  qualifies the one-hot register write enable
wb_sel  out  2  00 ALU result, 01 mem_rdata, 10 PC
pc  out  16  current PC
state  out  3  FSM state, debug

Behaviour:
- Reset, synchronous and active-high, with priority over everything. On reset: state=FETCH, pc=RESET_PC, IR=16'h0000. On the following cycle: mem_we=0, reg_wen=0, wb_sel=00, mem_addr=RESET_PC.
- Reset asserted in any state, including mid-LOAD or mid-STOR, aborts the instruction. No register write or memory write occurs in the reset cycle.
- Field outputs are driven combinationally from IR at all times. They are meaningful from EXEC onward.
- FSM states are FETCH=0, LATCH=1, EXEC=2, MEMRD=3. Values 4–7 are illegal and go to FETCH with no strobes.
- FETCH: mem_addr=pc, no strobes. Next state is LATCH.
- LATCH: IR<=mem_rdata, pc<=pc+1 (wraps 16'hFFFF to 16'h0000), no strobes. Next state is EXEC.
- EXEC decode uses op=IR[15:12] and ext=IR[7:4]:
  - Register ALU, op 0000 or 1000: imm_sel=0, wb_sel=00, reg_wen=1, then FETCH. Compare (op 0000 with ext 1011) has reg_wen=0.
  - Immediate ALU, any op not in {0000,0100,1000,1100}: imm_sel=1, wb_sel=00, reg_wen=1, then FETCH. Compare-immediate (op 1011) has reg_wen=0.
  - LOAD, op 0100 with ext 0000: mem_addr=src_data, no strobes, then MEMRD.
  - STOR, op 0100 with ext 0100: mem_addr=src_data, mem_we=1 for exactly this cycle, then FETCH.
  - JAL, op 0100 with ext 1000: reg_wen=1, wb_sel=10 (writes the already-incremented pc), pc<=src_data, then FETCH.
  - JCOND, op 0100 with ext 1100: pc<=src_data if cond_true, else pc unchanged. No reg write. Then FETCH.
  - Bcond, op 1100: if cond_true, pc<=pc + sext(IR[7:0]), where pc is the already-incremented value and the add wraps mod 2^16. No reg write. Then FETCH.
  - Any other op 0100 ext value: NOP, no strobes, then FETCH.
- MEMRD: mem_rdata is valid. reg_wen=1, wb_sel=01, mem_addr held at src_data. Next state is FETCH.
- reg_wen and mem_we are never both 1 in the same cycle. Each is high for at most one cycle per instruction.
- Latency: ALU, STOR, jump and branch instructions take 3 cycles. LOAD takes 4 cycles.
- JAL with rdst equal to rsrc: the jump target uses the src_data value sampled in EXEC, i.e. the old register value.

Test Plan:
- Reset then mem[0]=16'h0152 (ADD r1,r2): required sequence is FETCH, LATCH, EXEC. In EXEC: rdst_field=1, rsrc_field=2, alu_op=8'h05, imm_sel=0, reg_wen=1. pc=1 after LATCH. Next FETCH has mem_addr=1.
- mem[1]=16'h53F6 (ADDI r3,-10): in EXEC, imm_field=8'hF6, imm_sel=1, reg_wen=1. Compare 16'hB3F6 must give reg_wen=0.
- LOAD 16'h4405 with src_data=16'h0040: in EXEC, mem_addr=16'h0040 and reg_wen=0. In MEMRD, reg_wen=1 and wb_sel=01. Total 4 cycles with mem_we=0 throughout.
- STOR 16'h4645 with src_data=16'h0080: mem_we=1 only in EXEC, mem_addr=16'h0080, reg_wen=0.
- Bcond 16'hC0FE at address 16'h0010, cond_true=1: pc becomes 16'h000F. Same instruction with cond_true=0: pc becomes 16'h0011. JAL 16'h4E83 with src_data=16'h1234: reg_wen=1, wb_sel=10, pc becomes 16'h1234.
- PC wrap and abort: fetch at 16'hFFFF must give pc=16'h0000 after LATCH. Reset asserted in MEMRD must give reg_wen=0 in that cycle, then state=FETCH and pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Multi-cycle fetch/decode/control sequencer for the 16-bit CPU.
// Owns PC and IR and produces the memory, register-write and PC-update strobes.
module instr_fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] src_data,
    input  logic        cond_true,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  rsrc_field,
    output logic [3:0]  rdst_field,
    output logic [7:0]  imm_field,
    output logic [3:0]  cond_field,
    output logic [7:0]  alu_op,
    output logic        imm_sel,
    output logic        reg_wen,
    output logic [1:0]  wb_sel,
    output logic [15:0] pc,
    output logic [2:0]  state
);

    localparam int unsigned DW = 16;
    localparam int unsigned IW = 8;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LATCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEMRD = 3'd3
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   pc_q;
    logic [DW-1:0]   ir_q;

    // Instruction class decode from the latched IR
    logic [3:0]      op;
    logic [3:0]      ext;
    logic            is_mem_grp;
    logic            is_load;
    logic            is_stor;
    logic            is_jal;
    logic            is_jcond;
    logic            is_bcond;
    logic            is_reg_alu;
    logic            is_imm_alu;
    logic            is_cmp;
    logic            is_cmpi;
    logic [DW-1:0]   imm_sext;

    always_comb begin
        op         = ir_q[15:12];
        ext        = ir_q[7:4];
        is_mem_grp = (op == 4'b0100);
        is_load    = is_mem_grp && (ext == 4'b0000);
        is_stor    = is_mem_grp && (ext == 4'b0100);
        is_jal     = is_mem_grp && (ext == 4'b1000);
        is_jcond   = is_mem_grp && (ext == 4'b1100);
        is_bcond   = (op == 4'b1100);
        is_reg_alu = (op == 4'b0000) || (op == 4'b1000);
        is_imm_alu = !((op == 4'b0000) || (op == 4'b0100) ||
                       (op == 4'b1000) || (op == 4'b1100));
        is_cmp     = (op == 4'b0000) && (ext == 4'b1011);
        is_cmpi    = (op == 4'b1011);
        imm_sext   = {{(DW-IW){ir_q[7]}}, ir_q[7:0]};
    end

    // Sequencer state, PC and IR
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_LATCH;
                S_LATCH: begin
                    ir_q    <= mem_rdata;
                    pc_q    <= pc_q + DW'(1);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= is_load ? S_MEMRD : S_FETCH;
                    // pc already points past this instruction here
                    if (is_jal || (is_jcond && cond_true)) begin
                        pc_q <= src_data;
                    end else if (is_bcond && cond_true) begin
                        pc_q <= pc_q + imm_sext;
                    end
                end
                S_MEMRD: state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Strobes follow the current state; reset squashes any write in flight
    always_comb begin
        mem_addr = pc_q;
        mem_we   = 1'b0;
        reg_wen  = 1'b0;
        imm_sel  = 1'b0;
        wb_sel   = WB_ALU;
        case (state_q)
            S_EXEC: begin
                if (is_reg_alu) begin
                    reg_wen = !is_cmp;
                end else if (is_imm_alu) begin
                    imm_sel = 1'b1;
                    reg_wen = !is_cmpi;
                end else if (is_load) begin
                    mem_addr = src_data;
                end else if (is_stor) begin
                    mem_addr = src_data;
                    mem_we   = 1'b1;
                end else if (is_jal) begin
                    reg_wen = 1'b1;
                    wb_sel  = WB_PC;
                end
            end
            S_MEMRD: begin
                mem_addr = src_data;
                reg_wen  = 1'b1;
                wb_sel   = WB_MEM;
            end
            default: ;
        endcase
        if (reset) begin
            mem_we  = 1'b0;
            reg_wen = 1'b0;
        end
    end

    assign rsrc_field = ir_q[3:0];
    assign rdst_field = ir_q[11:8];
    assign imm_field  = ir_q[7:0];
    assign cond_field = ir_q[11:8];
    assign alu_op     = {ir_q[15:12], ir_q[7:4]};
    assign pc         = pc_q;
    assign state      = state_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: instruction table plus scoreboard,
// followed by reset-abort sequences in MEMRD and STOR.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_rdata;
    logic [15:0] src_data;
    logic        cond_true;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [3:0]  rsrc_field;
    logic [3:0]  rdst_field;
    logic [7:0]  imm_field;
    logic [3:0]  cond_field;
    logic [7:0]  alu_op;
    logic        imm_sel;
    logic        reg_wen;
    logic [1:0]  wb_sel;
    logic [15:0] pc;
    logic [2:0]  state;

    instr_fetch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .src_data(src_data),
        .cond_true(cond_true), .mem_addr(mem_addr), .mem_we(mem_we),
        .rsrc_field(rsrc_field), .rdst_field(rdst_field), .imm_field(imm_field),
        .cond_field(cond_field), .alu_op(alu_op), .imm_sel(imm_sel),
        .reg_wen(reg_wen), .wb_sel(wb_sel), .pc(pc), .state(state)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [logic [15:0]];

    // Synchronous-read memory
    always @(posedge clk) begin
        if ($isunknown(mem_addr) || !mem.exists(mem_addr)) mem_rdata <= 16'h0000;
        else mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] src;
        logic        cond;
        logic        exp_wen;
        logic        exp_we;
        logic        exp_imm;
        logic [1:0]  exp_wb;
        logic        chk_addr;
        logic [15:0] exp_addr;
        int          exp_lat;
        int          exp_writes;
        logic [15:0] exp_pc;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [15:0] pc_exec;
    } sb_t;

    vec_t        tbl [$];
    sb_t         sb  [$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] pc_m;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] src,
                                input logic cond, input logic wen, input logic we,
                                input logic imm, input logic [1:0] wb, input logic ca,
                                input logic [15:0] addr, input int lat, input int wr,
                                input logic [15:0] epc);
        vec_t r;
        r.instr = instr; r.src = src; r.cond = cond; r.exp_wen = wen; r.exp_we = we;
        r.exp_imm = imm; r.exp_wb = wb; r.chk_addr = ca; r.exp_addr = addr;
        r.exp_lat = lat; r.exp_writes = wr; r.exp_pc = epc;
        return r;
    endfunction

    task automatic run_instr(input vec_t v);
        sb_t e;
        sb_t got;
        int  cycles = 0;
        int  wens = 0;
        int  wes = 0;
        bit  done = 0;
        chk("fetch_state", 16'(state), 16'd0);
        chk("fetch_addr", mem_addr, pc_m);
        mem[pc_m]  = v.instr;
        src_data   = v.src;
        cond_true  = v.cond;
        e.v        = v;
        e.pc_exec  = 16'(pc_m + 16'd1);
        sb.push_back(e);
        for (int k = 0; k < 8 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            wens += int'(reg_wen);
            wes  += int'(mem_we);
            chk("wen_we_exclusive", 16'(reg_wen & mem_we), 16'd0);
            if (state == 3'd2) begin
                chk("sb_depth", 16'(sb.size()), 16'd1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    chk("exec_pc", pc, got.pc_exec);
                    chk("exec_reg_wen", 16'(reg_wen), 16'(got.v.exp_wen));
                    chk("exec_mem_we", 16'(mem_we), 16'(got.v.exp_we));
                    chk("exec_imm_sel", 16'(imm_sel), 16'(got.v.exp_imm));
                    chk("exec_wb_sel", 16'(wb_sel), 16'(got.v.exp_wb));
                    chk("exec_rdst", 16'(rdst_field), 16'(got.v.instr[11:8]));
                    chk("exec_rsrc", 16'(rsrc_field), 16'(got.v.instr[3:0]));
                    chk("exec_imm", 16'(imm_field), 16'(got.v.instr[7:0]));
                    chk("exec_cond", 16'(cond_field), 16'(got.v.instr[11:8]));
                    chk("exec_alu_op", 16'(alu_op), {8'h00, got.v.instr[15:12], got.v.instr[7:4]});
                    if (got.v.chk_addr) chk("exec_mem_addr", mem_addr, got.v.exp_addr);
                end
            end else if (state == 3'd3) begin
                chk("memrd_reg_wen", 16'(reg_wen), 16'd1);
                chk("memrd_wb_sel", 16'(wb_sel), 16'd1);
                chk("memrd_addr", mem_addr, v.src);
            end else if (state == 3'd0) begin
                done = 1;
            end
        end
        chk("instr_complete", 16'(done), 16'd1);
        chk("latency", 16'(cycles), 16'(v.exp_lat));
        chk("reg_write_count", 16'(wens), 16'(v.exp_writes));
        chk("mem_write_count", 16'(wes), 16'(v.exp_we));
        chk("pc_after", pc, v.exp_pc);
        pc_m = v.exp_pc;
    endtask

    initial begin
        reset     = 1'b1;
        src_data  = 16'h0000;
        cond_true = 1'b0;
        // instr, src, cond, wen, we, imm, wb, chk_addr, addr, lat, writes, pc_after
        tbl.push_back(mk(16'h0152, 16'h0000, 0, 1, 0, 0, 2'b00, 0, 16'h0000, 3, 1, 16'h0001)); // ADD
        tbl.push_back(mk(16'h53F6, 16'h0000, 0, 1, 0, 1, 2'b00, 0, 16'h0000, 3, 1, 16'h0002)); // ADDI
        tbl.push_back(mk(16'hB3F6, 16'h0000, 0, 0, 0, 1, 2'b00, 0, 16'h0000, 3, 0, 16'h0003)); // CMPI
        tbl.push_back(mk(16'h03B1, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'h0004)); // CMP
        tbl.push_back(mk(16'h4405, 16'h0040, 0, 0, 0, 0, 2'b00, 1, 16'h0040, 4, 1, 16'h0005)); // LOAD
        tbl.push_back(mk(16'h4645, 16'h0080, 0, 0, 1, 0, 2'b00, 1, 16'h0080, 3, 0, 16'h0006)); // STOR
        tbl.push_back(mk(16'h4E83, 16'h1234, 0, 1, 0, 0, 2'b10, 0, 16'h0000, 3, 1, 16'h1234)); // JAL
        tbl.push_back(mk(16'h4AC3, 16'h0010, 1, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'h0010)); // JCOND taken
        tbl.push_back(mk(16'hC0FE, 16'h0000, 1, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'h000F)); // Bcond back
        tbl.push_back(mk(16'h4AC3, 16'h9999, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'h0010)); // JCOND not taken
        tbl.push_back(mk(16'hC0FE, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'h0011)); // Bcond not taken
        tbl.push_back(mk(16'h4410, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'h0012)); // NOP
        tbl.push_back(mk(16'h4AC3, 16'hFFFF, 1, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'hFFFF)); // JCOND to FFFF
        tbl.push_back(mk(16'h0152, 16'h0000, 0, 1, 0, 0, 2'b00, 0, 16'h0000, 3, 1, 16'h0000)); // ADD, pc wraps
        tbl.push_back(mk(16'h8123, 16'h0000, 0, 1, 0, 0, 2'b00, 0, 16'h0000, 3, 1, 16'h0001)); // reg ALU op 8
        tbl.push_back(mk(16'hC005, 16'h0000, 1, 0, 0, 0, 2'b00, 0, 16'h0000, 3, 0, 16'h0007)); // Bcond fwd

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_we", 16'(mem_we), 16'd0);
        chk("rst_reg_wen", 16'(reg_wen), 16'd0);
        chk("rst_wb_sel", 16'(wb_sel), 16'd0);
        chk("rst_ir", 16'({rdst_field, imm_field}), 16'h0000);
        pc_m = 16'h0000;

        foreach (tbl[i]) run_instr(tbl[i]);

        // Reset during MEMRD aborts the load write-back
        mem[pc_m] = 16'h4405;
        src_data  = 16'h0040;
        cond_true = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_ld_state", 16'(state), 16'd3);
        chk("abort_ld_wen_pre", 16'(reg_wen), 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_ld_wen", 16'(reg_wen), 16'd0);
        chk("abort_ld_we", 16'(mem_we), 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ld_state_after", 16'(state), 16'd0);
        chk("abort_ld_pc_after", pc, 16'h0000);
        chk("abort_ld_addr_after", mem_addr, 16'h0000);
        chk("abort_ld_ir_after", 16'({rdst_field, imm_field}), 16'h0000);

        // Reset during STOR EXEC squashes the memory write
        mem[16'h0000] = 16'h4645;
        src_data      = 16'h0080;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("abort_st_state", 16'(state), 16'd2);
        chk("abort_st_we_pre", 16'(mem_we), 16'd1);
        reset = 1'b1;
        #1;
        chk("abort_st_we", 16'(mem_we), 16'd0);
        chk("abort_st_wen", 16'(reg_wen), 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_st_state_after", 16'(state), 16'd0);
        chk("abort_st_pc_after", pc, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
